// File: rtl/seg_scan.sv
// Time-multiplexed common-anode 7-segment scanner with tear-free frame-boundary updates.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_value_in,
    output logic [NUM_DIGITS-1:0]   o_anode,
    output logic [3:0]              o_digit,
    output logic                    o_frame_done,
    output logic                    o_pending
);

    localparam int DIV_W  = $clog2(REFRESH_DIV);
    localparam int SLOT_W = $clog2(NUM_DIGITS);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0]  DEAD_LAST = DIV_W'(DEAD_CYCLES - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);

    typedef enum logic {
        S_DEAD,
        S_DRIVE
    } state_t;

    state_t                  r_state;
    logic [DIV_W-1:0]        r_div;
    logic [SLOT_W-1:0]       r_slot;
    logic [4*NUM_DIGITS-1:0] r_display;
    logic [4*NUM_DIGITS-1:0] r_pending_val;
    logic                    w_slot_end;
    logic                    w_frame_end;
    logic [3:0]              w_slot_digit;
    logic [NUM_DIGITS-1:0]   w_anode_on;
    logic                    w_blank;

    assign w_slot_end  = (r_div == DIV_LAST);
    assign w_frame_end = w_slot_end && (r_slot == SLOT_LAST);
    assign w_anode_on  = ~(NUM_DIGITS'(1) << r_slot);

    always_comb begin
        w_slot_digit = r_display[3:0];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_slot == SLOT_W'(i)) begin
                w_slot_digit = r_display[4*i +: 4];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // w_zero_from[i] is set when digit i and every more-significant digit are zero
    logic [NUM_DIGITS-1:0] w_zero_from;

    always_comb begin
        logic all_zero;
        all_zero    = 1'b1;
        w_zero_from = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero       = all_zero && (r_display[4*i +: 4] == 4'h0);
            w_zero_from[i] = all_zero;
        end
    end

    always_comb begin
        w_blank = 1'b0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (r_slot == SLOT_W'(i)) begin
                w_blank = w_zero_from[i];
            end
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    // Outputs are computed from the current phase, so they lag the divider by one cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_DEAD;
            r_div         <= '0;
            r_slot        <= '0;
            r_display     <= '0;
            r_pending_val <= '0;
            o_anode       <= {NUM_DIGITS{1'b1}};
            o_digit       <= 4'hF;
            o_frame_done  <= 1'b0;
            o_pending     <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_div   <= '0;
                r_state <= S_DEAD;
                r_slot  <= (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;
            end else begin
                r_div <= r_div + 1'b1;
                if (r_div == DEAD_LAST) begin
                    r_state <= S_DRIVE;
                end
            end

            case (r_state)
                S_DRIVE: begin
                    o_anode <= w_anode_on;
                    o_digit <= w_blank ? 4'hF : w_slot_digit;
                end
                default: begin
                    o_anode <= {NUM_DIGITS{1'b1}};
                    o_digit <= 4'hF;
                end
            endcase

            o_frame_done <= w_frame_end;

            // A load coinciding with the frame end is captured after the old value commits
            if (w_frame_end && o_pending) begin
                r_display <= r_pending_val;
            end
            if (i_load) begin
                r_pending_val <= i_value_in;
                o_pending     <= 1'b1;
            end else if (w_frame_end) begin
                o_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2.
// k counts rising edges since reset release; outputs are sampled on the falling edge.
module tb_seg_scan;

    logic        clk = 1'b0;
    logic        rstN;
    logic        load;
    logic [15:0] valueIn;
    logic [3:0]  anode;
    logic [3:0]  digit;
    logic        frameDone;
    logic        pending;

    int          k;
    int          checks;
    int          failures;

    always #5 clk = ~clk;

    seg_scan #(
        .NUM_DIGITS (4),
        .REFRESH_DIV(8),
        .DEAD_CYCLES(2)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_load      (load),
        .i_value_in  (valueIn),
        .o_anode     (anode),
        .o_digit     (digit),
        .o_frame_done(frameDone),
        .o_pending   (pending)
    );

    // After edge kk the outputs reflect divider phase (kk-1)%8 of slot ((kk-1)/8)%4
    function automatic logic [3:0] expAnode(int kk);
        int p;
        int s;
        if (kk == 0) return 4'hF;
        p = (kk - 1) % 8;
        s = ((kk - 1) / 8) % 4;
        if (p < 2) return 4'hF;
        return ~(4'b0001 << s);
    endfunction

    function automatic logic [3:0] expDigit(int kk, logic [15:0] disp);
        int          p;
        int          s;
        logic [15:0] upper;
        if (kk == 0) return 4'hF;
        p = (kk - 1) % 8;
        s = ((kk - 1) / 8) % 4;
        if (p < 2) return 4'hF;
        upper = disp >> (4 * s);
`ifdef LEADING_ZERO_BLANK_EN
        if (s > 0 && upper == 16'h0000) return 4'hF;
`endif
        return upper[3:0];
    endfunction

    function automatic logic expFrameDone(int kk);
        return (kk > 0) && (kk % 32 == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstN    = 1'b0;
        load    = 1'b0;
        valueIn = 16'h0000;
        repeat (2) @(negedge clk);
        checks++;
        if (anode !== 4'hF) begin failures++; $display("[TB] FAIL reset_anode got=%b exp=1111", anode); end
        checks++;
        if (digit !== 4'hF) begin failures++; $display("[TB] FAIL reset_digit got=%h exp=f", digit); end
        checks++;
        if (frameDone !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_done got=%b exp=0", frameDone); end
        checks++;
        if (pending !== 1'b0) begin failures++; $display("[TB] FAIL reset_pending got=%b exp=0", pending); end
        rstN = 1'b1;
        k    = 0;
    endtask

    task automatic test_scan();
        while (k < 64) begin
            tick();
            checks++;
            if (anode !== expAnode(k)) begin failures++; $display("[TB] FAIL scan_anode k=%0d got=%b exp=%b", k, anode, expAnode(k)); end
            checks++;
            if (digit !== expDigit(k, 16'h0000)) begin failures++; $display("[TB] FAIL scan_digit k=%0d got=%h exp=%h", k, digit, expDigit(k, 16'h0000)); end
            checks++;
            if (frameDone !== expFrameDone(k)) begin failures++; $display("[TB] FAIL scan_frame_done k=%0d got=%b exp=%b", k, frameDone, expFrameDone(k)); end
            checks++;
            if (pending !== 1'b0) begin failures++; $display("[TB] FAIL scan_pending k=%0d got=%b exp=0", k, pending); end
        end
    endtask

    task automatic test_load();
        logic [15:0] shown;
        logic        expPend;
        while (k < 128) begin
            load    = (k == 72);
            valueIn = 16'h1234;
            tick();
            load    = 1'b0;
            shown   = (k <= 96) ? 16'h0000 : 16'h1234;
            expPend = (k >= 73 && k < 96);
            checks++;
            if (anode !== expAnode(k)) begin failures++; $display("[TB] FAIL load_anode k=%0d got=%b exp=%b", k, anode, expAnode(k)); end
            checks++;
            if (digit !== expDigit(k, shown)) begin failures++; $display("[TB] FAIL load_digit k=%0d got=%h exp=%h", k, digit, expDigit(k, shown)); end
            checks++;
            if (frameDone !== expFrameDone(k)) begin failures++; $display("[TB] FAIL load_frame_done k=%0d got=%b exp=%b", k, frameDone, expFrameDone(k)); end
            checks++;
            if (pending !== expPend) begin failures++; $display("[TB] FAIL load_pending k=%0d got=%b exp=%b", k, pending, expPend); end
        end
    endtask

    task automatic test_last_load_wins();
        logic [15:0] shown;
        logic        expPend;
        while (k < 192) begin
            load    = (k == 130) || (k == 140);
            valueIn = (k == 130) ? 16'h1111 : 16'h9876;
            tick();
            load    = 1'b0;
            shown   = (k <= 160) ? 16'h1234 : 16'h9876;
            expPend = (k >= 131 && k < 160);
            checks++;
            if (digit !== expDigit(k, shown)) begin failures++; $display("[TB] FAIL last_wins_digit k=%0d got=%h exp=%h", k, digit, expDigit(k, shown)); end
            checks++;
            if (anode !== expAnode(k)) begin failures++; $display("[TB] FAIL last_wins_anode k=%0d got=%b exp=%b", k, anode, expAnode(k)); end
            checks++;
            if (pending !== expPend) begin failures++; $display("[TB] FAIL last_wins_pending k=%0d got=%b exp=%b", k, pending, expPend); end
        end
    endtask

    task automatic test_load_at_frame_end();
        logic [15:0] shown;
        logic        expPend;
        while (k < 352) begin
            load    = (k == 223) || (k == 260) || (k == 287);
            valueIn = (k == 223) ? 16'h5555 : (k == 260) ? 16'hAAAA : 16'h4321;
            tick();
            load    = 1'b0;
            shown   = (k <= 256) ? 16'h9876 : (k <= 288) ? 16'h5555 : (k <= 320) ? 16'hAAAA : 16'h4321;
            expPend = (k >= 224 && k < 256) || (k >= 261 && k < 320);
            checks++;
            if (digit !== expDigit(k, shown)) begin failures++; $display("[TB] FAIL frame_end_digit k=%0d got=%h exp=%h", k, digit, expDigit(k, shown)); end
            checks++;
            if (anode !== expAnode(k)) begin failures++; $display("[TB] FAIL frame_end_anode k=%0d got=%b exp=%b", k, anode, expAnode(k)); end
            checks++;
            if (frameDone !== expFrameDone(k)) begin failures++; $display("[TB] FAIL frame_end_done k=%0d got=%b exp=%b", k, frameDone, expFrameDone(k)); end
            checks++;
            if (pending !== expPend) begin failures++; $display("[TB] FAIL frame_end_pending k=%0d got=%b exp=%b", k, pending, expPend); end
        end
    endtask

    task automatic test_reset_mid_frame();
        while (k < 371) begin
            load    = (k == 360);
            valueIn = 16'h1111;
            tick();
            load    = 1'b0;
            checks++;
            if (digit !== expDigit(k, 16'h4321)) begin failures++; $display("[TB] FAIL mid_reset_pre_digit k=%0d got=%h exp=%h", k, digit, expDigit(k, 16'h4321)); end
        end
        checks++;
        if (anode !== 4'b1011) begin failures++; $display("[TB] FAIL mid_reset_pre_anode got=%b exp=1011", anode); end
        checks++;
        if (pending !== 1'b1) begin failures++; $display("[TB] FAIL mid_reset_pre_pending got=%b exp=1", pending); end
        #2 rstN = 1'b0;
        #1;
        checks++;
        if (anode !== 4'hF) begin failures++; $display("[TB] FAIL mid_reset_anode got=%b exp=1111", anode); end
        checks++;
        if (digit !== 4'hF) begin failures++; $display("[TB] FAIL mid_reset_digit got=%h exp=f", digit); end
        checks++;
        if (pending !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_pending got=%b exp=0", pending); end
        @(negedge clk);
        rstN = 1'b1;
        k    = 0;
        while (k < 40) begin
            tick();
            checks++;
            if (anode !== expAnode(k)) begin failures++; $display("[TB] FAIL post_reset_anode k=%0d got=%b exp=%b", k, anode, expAnode(k)); end
            checks++;
            if (digit !== expDigit(k, 16'h0000)) begin failures++; $display("[TB] FAIL post_reset_digit k=%0d got=%h exp=%h", k, digit, expDigit(k, 16'h0000)); end
            checks++;
            if (frameDone !== expFrameDone(k)) begin failures++; $display("[TB] FAIL post_reset_done k=%0d got=%b exp=%b", k, frameDone, expFrameDone(k)); end
        end
    endtask

    task automatic test_leading_zero();
        logic [15:0] shown;
        logic        expPend;
        while (k < 160) begin
            load    = (k == 40) || (k == 100);
            valueIn = (k == 40) ? 16'h0070 : 16'h0000;
            tick();
            load    = 1'b0;
            shown   = (k <= 64) ? 16'h0000 : (k <= 128) ? 16'h0070 : 16'h0000;
            expPend = (k >= 41 && k < 64) || (k >= 101 && k < 128);
            checks++;
            if (digit !== expDigit(k, shown)) begin failures++; $display("[TB] FAIL lzb_digit k=%0d got=%h exp=%h", k, digit, expDigit(k, shown)); end
            checks++;
            if (anode !== expAnode(k)) begin failures++; $display("[TB] FAIL lzb_anode k=%0d got=%b exp=%b", k, anode, expAnode(k)); end
            checks++;
            if (pending !== expPend) begin failures++; $display("[TB] FAIL lzb_pending k=%0d got=%b exp=%b", k, pending, expPend); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        k        = 0;
        test_reset();
        test_scan();
        test_load();
        test_last_load_wins();
        test_load_at_frame_end();
        test_reset_mid_frame();
        test_leading_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
